// File: rtl/apolo_pkg.sv
// Shared definitions for the APOLO pulse link: state encoding, counter width, µs-to-cycles.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apolo_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_MARK  = 3'd1,
        HDR_SPACE = 3'd2,
        BIT_MARK  = 3'd3,
        BIT_SPACE = 3'd4,
        STOP_MARK = 3'd5,
        GAP       = 3'd6
    } apolo_state_t;

    // Whole-MHz clock assumed; the receiver derives its thresholds the same way.
    function automatic logic [CNT_W-1:0] us_to_cycles(input int unsigned clk_freq,
                                                      input int unsigned us);
        return CNT_W'((clk_freq / 32'd1000000) * us);
    endfunction

endpackage

// File: rtl/apolo_interval_timer.sv
// Down-counter for timed intervals: load N-1, zero flag marks the last cycle of the interval.
// Latency: load takes effect on the next clock; zero is combinational from the count.
// Backpressure: none; the owner decides when to load.
module apolo_interval_timer
    import apolo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over counting; the count parks at zero between intervals.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apolo_pulse_tx.sv
// Pulse-width frame transmitter: header, LSB-first mark/space bits, stop mark, guard gap.
// Latency: line rises 1 cycle after accept; tx_ready only in IDLE, tx_valid ignored while busy.
// Backpressure: one word per frame; optional even-parity bit via APOLO_TX_PARITY_EN.
module apolo_pulse_tx
    import apolo_pkg::*;
#(
    parameter int unsigned clk_freq     = 100000000,
    parameter int          DATA_W       = 8,
    parameter int unsigned HDR_MARK_US  = 10,
    parameter int unsigned HDR_SPACE_US = 88,
    parameter int unsigned BIT_MARK_US  = 8,
    parameter int unsigned SPACE1_US    = 36,
    parameter int unsigned SPACE0_US    = 4,
    parameter int unsigned STOP_MARK_US = 8,
    parameter int unsigned GAP_US       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    // Counter reload values are cycles-1 so each state lasts exactly its cycle count.
    localparam logic [CNT_W-1:0] HDR_MARK_LD  = us_to_cycles(clk_freq, HDR_MARK_US)  - 1'b1;
    localparam logic [CNT_W-1:0] HDR_SPACE_LD = us_to_cycles(clk_freq, HDR_SPACE_US) - 1'b1;
    localparam logic [CNT_W-1:0] BIT_MARK_LD  = us_to_cycles(clk_freq, BIT_MARK_US)  - 1'b1;
    localparam logic [CNT_W-1:0] SPACE1_LD    = us_to_cycles(clk_freq, SPACE1_US)    - 1'b1;
    localparam logic [CNT_W-1:0] SPACE0_LD    = us_to_cycles(clk_freq, SPACE0_US)    - 1'b1;
    localparam logic [CNT_W-1:0] STOP_LD      = us_to_cycles(clk_freq, STOP_MARK_US) - 1'b1;
    localparam logic [CNT_W-1:0] GAP_LD       = us_to_cycles(clk_freq, GAP_US)       - 1'b1;

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    apolo_state_t      state;
    apolo_state_t      state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              rst_r;
    logic              accept;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              zero;
    logic              shift_en;
    logic              idx_clr;
    logic              cur_bit;

    assign tx_ready = (state == IDLE) & ~rst_r;
    assign busy     = (state != IDLE);
    assign accept   = tx_valid & tx_ready;

`ifdef APOLO_TX_PARITY_EN
    localparam logic [IDX_W-1:0] PAR_IDX = IDX_W'(DATA_W);
    logic parity_r;

    // Even parity of the accepted word, held for the extra bit slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            parity_r <= ^tx_data;
        end
    end

    assign cur_bit = (bit_idx == PAR_IDX) ? parity_r : shift_reg[0];
`else
    assign cur_bit = shift_reg[0];
`endif

    apolo_interval_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // Delayed reset keeps tx_ready low for the first cycle out of reset.
    always_ff @(posedge clk) begin
        rst_r <= rst;
    end

    // State register; reset aborts a frame in flight with no stop mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, timer reload and bit-stepping decisions.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = '0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HDR_MARK;
                    load      = 1'b1;
                    load_val  = HDR_MARK_LD;
                end
            end
            HDR_MARK: begin
                if (zero) begin
                    state_nxt = HDR_SPACE;
                    load      = 1'b1;
                    load_val  = HDR_SPACE_LD;
                end
            end
            HDR_SPACE: begin
                if (zero) begin
                    state_nxt = BIT_MARK;
                    load      = 1'b1;
                    load_val  = BIT_MARK_LD;
                    idx_clr   = 1'b1;
                end
            end
            BIT_MARK: begin
                if (zero) begin
                    state_nxt = BIT_SPACE;
                    load      = 1'b1;
                    load_val  = cur_bit ? SPACE1_LD : SPACE0_LD;
                end
            end
            BIT_SPACE: begin
                if (zero) begin
                    shift_en = 1'b1;
                    load     = 1'b1;
`ifdef APOLO_TX_PARITY_EN
                    if (bit_idx == PAR_IDX) begin
`else
                    if (bit_idx == LAST_IDX) begin
`endif
                        state_nxt = STOP_MARK;
                        load_val  = STOP_LD;
                    end else begin
                        state_nxt = BIT_MARK;
                        load_val  = BIT_MARK_LD;
                    end
                end
            end
            STOP_MARK: begin
                if (zero) begin
                    state_nxt = GAP;
                    load      = 1'b1;
                    load_val  = GAP_LD;
                end
            end
            GAP: begin
                if (zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level and completion strobe come straight from flops, so the pin cannot glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            tx_out <= (state_nxt == HDR_MARK) || (state_nxt == BIT_MARK) ||
                      (state_nxt == STOP_MARK);
            done   <= (state == GAP) && zero;
        end
    end

    // Payload shifter: loaded on accept, stepped LSB-first at each bit-space exit.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= tx_data;
        end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // Bit index: cleared entering the first bit, advanced with the shifter.
    always_ff @(posedge clk) begin
        if (rst || idx_clr) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

endmodule
